// File: rtl/acc_stim_gen.sv
`timescale 1ns/1ps
// acc_stim_gen
//   Hardware stimulus producer for the accumulator's valid/value input.
//   After a start condition it emits NUM_BURSTS bursts of BURST_LEN addends,
//   with GAP_CYCLES idle cycles between bursts. It keeps a running sum of
//   everything it sent and flags (sticky) any cycle in which the accumulator
//   disagrees with base + sum.
//
//   Optional build macro ACC_STIM_LFSR_EN: addends come from a 32-bit Galois
//   LFSR (taps 32,22,2,1, seed 1) instead of the arithmetic sequence
//   1, 1+STEP, 1+2*STEP, ...
//
// Ports
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cycles       in   free-running cycle count (CYC_W bits)
//   accumulator  in   accumulator register value (DATA_W bits)
//   enable       in   run/pause while bursting or in a gap
//   valid        out  addend valid this cycle (registered)
//   value        out  addend (registered)
//   sent_count   out  beats emitted so far, saturating at 16'hFFFF
//   expected     out  sum of emitted addends, mod 2^DATA_W
//   done         out  programme complete
//   mismatch     out  sticky accumulator check failure
module acc_stim_gen #(
   parameter int unsigned     DATA_W      = 32,
   parameter int unsigned     CYC_W       = 64,
   parameter int unsigned     BURST_LEN   = 4,
   parameter int unsigned     NUM_BURSTS  = 2,
   parameter int unsigned     GAP_CYCLES  = 2,
   parameter longint unsigned START_CYCLE = 10,
   parameter int unsigned     STEP        = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [CYC_W-1:0]  cycles,
   input  logic [DATA_W-1:0] accumulator,
   input  logic              enable,
   output logic              valid,
   output logic [DATA_W-1:0] value,
   output logic [15:0]       sent_count,
   output logic [DATA_W-1:0] expected,
   output logic              done,
   output logic              mismatch
);

   typedef enum logic [2:0] {S_IDLE, S_BURST, S_GAP, S_DRAIN, S_DONE} state_t;

   localparam logic [15:0]      LAST_BEAT  = 16'(BURST_LEN);
   localparam logic [15:0]      LAST_BURST = 16'(NUM_BURSTS - 1);
   localparam logic [15:0]      LAST_GAP   = 16'(GAP_CYCLES - 1);
   localparam logic [CYC_W-1:0] START_AT   = CYC_W'(START_CYCLE);

   state_t            state;
   logic [15:0]       beat_cnt;   // beats already emitted in the current burst
   logic [15:0]       burst_cnt;  // bursts completed before the current one
   logic [15:0]       gap_cnt;
   logic [DATA_W-1:0] base;       // accumulator value when the programme started
   logic [DATA_W-1:0] cur_val;    // addend to be emitted on the next beat
   logic              emit;

`ifdef ACC_STIM_LFSR_EN
   logic [31:0] lfsr;
   assign cur_val = DATA_W'(lfsr);
`else
   logic [DATA_W-1:0] next_val;
   assign cur_val = next_val;
`endif

   // Decides whether the next cycle carries a beat.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      emit = 1'b0;
      case (state)
         S_IDLE:  emit = enable && (cycles >= START_AT);
         S_BURST: emit = enable && ((beat_cnt != LAST_BEAT) ||
                                    ((burst_cnt != LAST_BURST) && (GAP_CYCLES == 0)));
         S_GAP:   emit = enable && (gap_cnt == LAST_GAP);
         default: emit = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below reads the value from before this edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         valid      <= 1'b0;
         value      <= '0;
         sent_count <= '0;
         expected   <= '0;
         done       <= 1'b0;
         mismatch   <= 1'b0;
         base       <= '0;
         beat_cnt   <= '0;
         burst_cnt  <= '0;
         gap_cnt    <= '0;
`ifdef ACC_STIM_LFSR_EN
         lfsr       <= 32'h1;
`else
         next_val   <= DATA_W'(1);
`endif
      end else begin
         valid <= emit;
         if (emit) begin
            value <= cur_val;
`ifdef ACC_STIM_LFSR_EN
            lfsr  <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
`else
            next_val <= next_val + DATA_W'(STEP);
`endif
         end

         // Book-keep the beat currently on the bus; the accumulator absorbs it
         // on this same edge, so expected and accumulator stay in lock-step.
         if (valid) begin
            expected <= expected + value;
            if (sent_count != 16'hFFFF)
               sent_count <= sent_count + 16'd1;
         end

         if (state inside {S_BURST, S_GAP, S_DRAIN})
            mismatch <= mismatch | (accumulator != base + expected);

         case (state)
            S_IDLE: begin
               if (emit) begin
                  base     <= accumulator;
                  beat_cnt <= 16'd1;
                  state    <= S_BURST;
               end
            end
            S_BURST: begin
               if (enable) begin
                  if (beat_cnt != LAST_BEAT) begin
                     beat_cnt <= beat_cnt + 16'd1;
                  end else if (burst_cnt != LAST_BURST) begin
                     burst_cnt <= burst_cnt + 16'd1;
                     if (GAP_CYCLES == 0) begin
                        beat_cnt <= 16'd1;  // back-to-back: first beat of next burst already emitted
                     end else begin
                        beat_cnt <= 16'd0;
                        gap_cnt  <= 16'd0;
                        state    <= S_GAP;
                     end
                  end else begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_GAP: begin
               if (enable) begin
                  if (gap_cnt == LAST_GAP) begin
                     gap_cnt  <= 16'd0;
                     beat_cnt <= 16'd1;
                     state    <= S_BURST;
                  end else begin
                     gap_cnt <= gap_cnt + 16'd1;
                  end
               end
            end
            S_DRAIN: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            default: begin
               done <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_stim_gen.sv
`timescale 1ns/1ps
// tb_acc_stim_gen
//   Self-checking bench for acc_stim_gen. Two instances share clock, reset,
//   enable and cycles: the default configuration, and an 8-bit back-to-back
//   variant (GAP_CYCLES=0, STEP=100). The bench owns the accumulator models
//   and a slot-list reference model of the programme.
module tb_acc_stim_gen;

   localparam int BL    = 4;
   localparam int NB    = 2;
   localparam int GAP   = 2;
   localparam int START = 10;
   localparam int STEP  = 1;

   localparam int GAP_SLOT   = -1;
   localparam int DRAIN_SLOT = -2;
   localparam int DONE_SLOT  = -3;

   logic        clock    = 1'b0;
   logic        reset_n  = 1'b0;
   logic        enable   = 1'b0;
   logic [63:0] cycles   = 64'd0;
   logic        cyc_clr  = 1'b1;
   logic [31:0] acc      = 32'd0;
   logic [7:0]  acc8     = 8'd0;
   logic        acc_load = 1'b1;
   logic [31:0] acc_init = 32'd0;
   int          drop_beat = -1;
   int          beat_seen = 0;

   logic        valid, done, mismatch;
   logic [31:0] value, expected;
   logic [15:0] sent_count;
   logic        valid2, done2, mismatch2;
   logic [7:0]  value2, expected2;
   logic [15:0] sent_count2;

   int checks = 0;
   int failures = 0;

   acc_stim_gen dut (
      .clock(clock), .reset_n(reset_n), .cycles(cycles), .accumulator(acc),
      .enable(enable), .valid(valid), .value(value), .sent_count(sent_count),
      .expected(expected), .done(done), .mismatch(mismatch)
   );

   acc_stim_gen #(.DATA_W(8), .GAP_CYCLES(0), .STEP(100)) dut2 (
      .clock(clock), .reset_n(reset_n), .cycles(cycles), .accumulator(acc8),
      .enable(enable), .valid(valid2), .value(value2), .sent_count(sent_count2),
      .expected(expected2), .done(done2), .mismatch(mismatch2)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycles <= cyc_clr ? 64'd0 : cycles + 64'd1;

   // Accumulator environment: adds every valid addend, optionally ignoring one.
   always @(posedge clock) begin
      if (acc_load) begin
         acc       <= acc_init;
         acc8      <= 8'd0;
         beat_seen <= 0;
      end else begin
         if (valid) begin
            beat_seen <= beat_seen + 1;
            if (beat_seen != drop_beat) acc <= acc + value;
         end
         if (valid2) acc8 <= acc8 + value2;
      end
   end

   // ---------------- reference model ----------------
   // The programme is a list of slots (beat k, gap, drain, done). Each enabled
   // edge moves one slot forward; a disabled edge shows an idle cycle instead.
   int          slots[$];
   bit          m_started, m_paused;
   int          m_pos;
   logic [31:0] m_base, m_sum;
   int          m_cnt;
   bit          m_mis;

   function automatic logic [31:0] beat_val(input int k);
      logic [31:0] r;
`ifdef ACC_STIM_LFSR_EN
      r = 32'h1;
      for (int i = 0; i < k; i++) r = {1'b0, r[31:1]} ^ (r[0] ? 32'h8020_0003 : 32'h0);
`else
      r = 32'd1 + 32'(k) * 32'(STEP);
`endif
      return r;
   endfunction

   function automatic int cur_slot();
      return m_started ? slots[m_pos] : GAP_SLOT;
   endfunction

   function automatic bit exp_valid();
      return m_started && !m_paused && (cur_slot() >= 0);
   endfunction

   function automatic bit exp_done();
      return m_started && (cur_slot() == DONE_SLOT);
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_started <= 1'b0;
         m_paused  <= 1'b0;
         m_pos     <= 0;
         m_base    <= 32'd0;
         m_sum     <= 32'd0;
         m_cnt     <= 0;
         m_mis     <= 1'b0;
      end else if (!m_started) begin
         if (enable && cycles >= 64'(START)) begin
            m_started <= 1'b1;
            m_pos     <= 0;
            m_base    <= acc;
         end
      end else begin
         if (exp_valid()) begin
            m_sum <= m_sum + beat_val(cur_slot());
            m_cnt <= m_cnt + 1;
         end
         if (cur_slot() != DONE_SLOT) m_mis <= m_mis | (acc != m_base + m_sum);
         if (cur_slot() == DRAIN_SLOT) begin
            m_pos    <= m_pos + 1;
            m_paused <= 1'b0;
         end else if (cur_slot() == DONE_SLOT) begin
            m_paused <= 1'b0;
         end else if (enable) begin
            m_pos    <= m_pos + 1;
            m_paused <= 1'b0;
         end else begin
            m_paused <= 1'b1;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         check("mdl_valid", 64'(valid), 64'(exp_valid()));
         if (exp_valid()) check("mdl_value", 64'(value), 64'(beat_val(cur_slot())));
         check("mdl_sent_count", 64'(sent_count), 64'(m_cnt));
         check("mdl_expected", 64'(expected), 64'(m_sum));
         check("mdl_done", 64'(done), 64'(exp_done()));
         check("mdl_mismatch", 64'(mismatch), 64'(m_mis));
      end
   end

   task automatic do_reset(input logic [31:0] init);
      @(negedge clock);
      reset_n  = 1'b0;
      cyc_clr  = 1'b1;
      acc_load = 1'b1;
      acc_init = init;
      #1;
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_value", 64'(value), 64'd0);
      check("rst_sent_count", 64'(sent_count), 64'd0);
      check("rst_expected", 64'(expected), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_mismatch", 64'(mismatch), 64'd0);
      check("rst_valid2", 64'(valid2), 64'd0);
      check("rst_expected2", 64'(expected2), 64'd0);
      check("rst_done2", 64'(done2), 64'd0);
      @(negedge clock);
      acc_load = 1'b0;
      cyc_clr  = 1'b0;
      reset_n  = 1'b1;
   endtask

   task automatic wait_cycle(input logic [63:0] c);
      int n = 0;
      while (cycles != c && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("reach_cycle", cycles, c);
   endtask

   task automatic run_to_done(input int budget, input bit rnd_en);
      int n = 0;
      while (!(done && exp_done()) && n < budget) begin
         @(negedge clock);
         if (rnd_en) enable = ($urandom_range(9) < 7);
         n++;
      end
      check("programme_complete", 64'(done && exp_done()), 64'd1);
   endtask

   typedef struct {
      int          cyc;
      bit          v;
      logic [31:0] val;
      bit          d;
      bit          v2;
      logic [7:0]  val2;
      bit          d2;
   } row_t;

   row_t        tbl[13];
   logic [31:0] acc_restart;

   initial begin
      for (int b = 0; b < NB; b++) begin
         for (int i = 0; i < BL; i++) slots.push_back(b * BL + i);
         if (b < NB - 1) for (int g = 0; g < GAP; g++) slots.push_back(GAP_SLOT);
      end
      slots.push_back(DRAIN_SLOT);
      slots.push_back(DONE_SLOT);

      //          cyc  v  val d  v2 val2 d2
      tbl[0]  = '{10, 0, 0, 0, 0, 0,   0};
      tbl[1]  = '{11, 1, 1, 0, 1, 1,   0};
      tbl[2]  = '{12, 1, 2, 0, 1, 101, 0};
      tbl[3]  = '{13, 1, 3, 0, 1, 201, 0};
      tbl[4]  = '{14, 1, 4, 0, 1, 45,  0};
      tbl[5]  = '{15, 0, 0, 0, 1, 145, 0};
      tbl[6]  = '{16, 0, 0, 0, 1, 245, 0};
      tbl[7]  = '{17, 1, 5, 0, 1, 89,  0};
      tbl[8]  = '{18, 1, 6, 0, 1, 189, 0};
      tbl[9]  = '{19, 1, 7, 0, 0, 0,   0};
      tbl[10] = '{20, 1, 8, 0, 0, 0,   1};
      tbl[11] = '{21, 0, 0, 0, 0, 0,   1};
      tbl[12] = '{22, 0, 0, 1, 0, 0,   1};

      // Run A: defaults, accumulator from 0, table of cycle-exact expectations
      enable = 1'b1;
      do_reset(32'd0);
      wait_cycle(64'd10);
      for (int i = 0; i < 13; i++) begin
         check("tbl_cycle", cycles, 64'(tbl[i].cyc));
         check("tbl_valid", 64'(valid), 64'(tbl[i].v));
         if (tbl[i].v) check("tbl_value", 64'(value), 64'(tbl[i].val));
         check("tbl_done", 64'(done), 64'(tbl[i].d));
         check("tbl_valid2", 64'(valid2), 64'(tbl[i].v2));
         if (tbl[i].v2) check("tbl_value2", 64'(value2), 64'(tbl[i].val2));
         check("tbl_done2", 64'(done2), 64'(tbl[i].d2));
         @(negedge clock);
      end
      check("a_expected", 64'(expected), 64'd36);
      check("a_acc", 64'(acc), 64'd36);
      check("a_sent_count", 64'(sent_count), 64'd8);
      check("a_mismatch", 64'(mismatch), 64'd0);
      check("a_expected2", 64'(expected2), 64'd248);
      check("a_acc8", 64'(acc8), 64'd248);
      check("a_sent_count2", 64'(sent_count2), 64'd8);
      check("a_mismatch2", 64'(mismatch2), 64'd0);

      // Run B: accumulator starts at 100
      do_reset(32'd100);
      run_to_done(100, 1'b0);
      check("b_acc", 64'(acc), 64'd136);
      check("b_expected", 64'(expected), 64'd36);
      check("b_mismatch", 64'(mismatch), 64'd0);

      // Run C: accumulator ignores beat 3
      drop_beat = 2;
      do_reset(32'd0);
      wait_cycle(64'd14);
      check("c_mismatch_before", 64'(mismatch), 64'd0);
      @(negedge clock);
      check("c_mismatch_after", 64'(mismatch), 64'd1);
      run_to_done(100, 1'b0);
      check("c_mismatch_end", 64'(mismatch), 64'd1);
      check("c_done", 64'(done), 64'd1);
      drop_beat = -1;

      // Run D: enable low for 3 cycles after beat 2
      do_reset(32'd0);
      wait_cycle(64'd12);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("d_paused_valid", 64'(valid), 64'd0);
      end
      enable = 1'b1;
      @(negedge clock);
      check("d_resume_valid", 64'(valid), 64'd1);
      check("d_resume_value", 64'(value), 64'd3);
      run_to_done(100, 1'b0);
      check("d_sent_count", 64'(sent_count), 64'd8);
      check("d_expected", 64'(expected), 64'd36);
      check("d_acc", 64'(acc), 64'd36);

      // Run E: asynchronous reset in the middle of the second burst
      do_reset(32'd0);
      wait_cycle(64'd18);
      #2;
      reset_n = 1'b0;
      #1;
      check("e_valid", 64'(valid), 64'd0);
      check("e_value", 64'(value), 64'd0);
      check("e_sent_count", 64'(sent_count), 64'd0);
      check("e_expected", 64'(expected), 64'd0);
      check("e_done", 64'(done), 64'd0);
      check("e_mismatch", 64'(mismatch), 64'd0);
      @(negedge clock);
      @(negedge clock);
      check("e_acc_at_restart", 64'(acc), 64'd15);
      acc_restart = acc;
      reset_n = 1'b1;
      run_to_done(100, 1'b0);
      check("e_expected_end", 64'(expected), 64'd36);
      check("e_acc_end", 64'(acc), 64'(acc_restart + 32'd36));
      check("e_mismatch_end", 64'(mismatch), 64'd0);

      // Random runs: random start value, random pauses, occasional dropped beat
      for (int r = 0; r < 20; r++) begin
         drop_beat = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1;
         enable = 1'b1;
         do_reset($urandom);
         run_to_done(300, 1'b1);
         if (drop_beat < 0) check("rnd_acc_end", 64'(acc), 64'(m_base + m_sum));
      end
      drop_beat = -1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
